uart_cmd_ctrl: RTL and testbench

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// UART command parser: SYNC/CMD/DATA/CHK frames drive config registers and
// return an ACK, NAK or read-back byte. Errors are counted with saturation.
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CLKS = 270000,
  parameter logic [7:0]  THRESH_RST   = 8'd128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] cfg_threshold,
  output logic [1:0] cfg_mode,
  output logic       cfg_enable,
  output logic       cfg_wr,
  output logic [7:0] err_count
);

  localparam int unsigned TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_CHK, S_EXEC, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d, data_q, data_d, chk_q, chk_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    thr_q, thr_d;
  logic [1:0]    mode_q, mode_d;
  logic          en_q, en_d;
  logic          wr_q, wr_d;
  logic [7:0]    err_q, err_d;
  logic          err_inc, in_get, timeout, bad;
  logic [7:0]    rsp;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    chk_d      = chk_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    thr_d      = thr_q;
    mode_d     = mode_q;
    en_d       = en_q;
    wr_d       = 1'b0;
    err_inc    = 1'b0;
    bad        = 1'b1;
    rsp        = NAK;
    in_get     = (state_q == S_CMD) || (state_q == S_DATA) || (state_q == S_CHK);
    timeout    = in_get && !rx_valid && (to_q == TO_LAST);

    case (state_q)
      S_IDLE: if (rx_valid && rx_data == SYNC) state_d = S_CMD;
      S_CMD: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          data_d  = rx_data;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          chk_d   = rx_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (chk_q == (cmd_q ^ data_q)) begin
          case (cmd_q)
            8'h01: begin thr_d  = data_q;      wr_d = 1'b1; bad = 1'b0; rsp = ACK; end
            8'h02: begin mode_d = data_q[1:0]; wr_d = 1'b1; bad = 1'b0; rsp = ACK; end
            8'h03: begin en_d   = data_q[0];   wr_d = 1'b1; bad = 1'b0; rsp = ACK; end
            8'h10: begin
              case (data_q)
                8'd0:    begin rsp = thr_q;          bad = 1'b0; end
                8'd1:    begin rsp = {6'b0, mode_q}; bad = 1'b0; end
                8'd2:    begin rsp = {7'b0, en_q};   bad = 1'b0; end
                default: ;
              endcase
            end
            default: ;
          endcase
        end
        tx_data_d  = rsp;
        tx_valid_d = 1'b1;
        // a NAK and an overrun in the same cycle still count as one error
        err_inc    = bad || rx_valid;
        state_d    = S_RESP;
      end
      S_RESP: begin
        err_inc = rx_valid;
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      state_d = S_IDLE;
      err_inc = 1'b1;
    end

    to_d  = (in_get && !rx_valid && state_d != S_IDLE) ? to_q + TW'(1) : '0;
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      data_q     <= '0;
      chk_q      <= '0;
      to_q       <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      thr_q      <= THRESH_RST;
      mode_q     <= '0;
      en_q       <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      chk_q      <= chk_d;
      to_q       <= to_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      thr_q      <= thr_d;
      mode_q     <= mode_d;
      en_q       <= en_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign cfg_threshold = thr_q;
  assign cfg_mode      = mode_q;
  assign cfg_enable    = en_q;
  assign cfg_wr        = wr_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frame table, corner-case sequences and
// random frames scored against a frame-level reference model.
module tb_uart_cmd_ctrl;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] cfg_threshold;
  logic [1:0] cfg_mode;
  logic       cfg_enable;
  logic       cfg_wr;
  logic [7:0] err_count;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] m_thr, m_err;
  logic [1:0] m_mode;
  logic       m_en;

  uart_cmd_ctrl #(.TIMEOUT_CLKS(TO), .THRESH_RST(8'd128)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cfg_threshold(cfg_threshold), .cfg_mode(cfg_mode), .cfg_enable(cfg_enable),
    .cfg_wr(cfg_wr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd, data, chk;
    int         dly;
    logic [7:0] exp_tx, exp_err;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic m_reset();
    m_thr = 8'h80; m_mode = 2'd0; m_en = 1'b0; m_err = 8'd0;
  endtask

  task automatic m_bump();
    if (m_err != 8'd255) m_err = m_err + 8'd1;
  endtask

  // Frame-level semantics: a good frame writes or reads, anything else NAKs.
  task automatic m_frame(input logic [7:0] c, d, k, output logic [7:0] r, output bit wr);
    bit ok;
    ok = 1'b0; wr = 1'b0; r = 8'h15;
    if (k == (c ^ d)) begin
      if (c == 8'h01) begin m_thr = d; ok = 1; wr = 1; r = 8'h06; end
      else if (c == 8'h02) begin m_mode = d[1:0]; ok = 1; wr = 1; r = 8'h06; end
      else if (c == 8'h03) begin m_en = d[0]; ok = 1; wr = 1; r = 8'h06; end
      else if (c == 8'h10 && d < 8'd3) begin
        ok = 1;
        r = (d == 0) ? m_thr : (d == 1) ? {6'b0, m_mode} : {7'b0, m_en};
      end
    end
    if (!ok) m_bump();
  endtask

  task automatic check_cfg(input string nm);
    check({nm, "_thr"},  cfg_threshold, m_thr);
    check({nm, "_mode"}, cfg_mode, m_mode);
    check({nm, "_en"},   cfg_enable, m_en);
    check({nm, "_err"},  err_count, m_err);
  endtask

  task automatic handshake(input string nm);
    tx_ready = 1'b1;
    tick();
    check({nm, "_txv_clr"}, tx_valid, 0);
    check({nm, "_wr_idle"}, cfg_wr, 0);
    tx_ready = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] c, d, k, input int dly, output logic [7:0] got);
    logic [7:0] e_tx;
    bit e_wr;
    m_frame(c, d, k, e_tx, e_wr);
    tx_ready = 1'b0;
    send(8'hA5); send(c); send(d); send(k);
    check("lat_early", tx_valid, 0);
    tick();
    check("txv", tx_valid, 1);
    check("txd", tx_data, e_tx);
    check("wr", cfg_wr, e_wr);
    check_cfg("exec");
    got = tx_data;
    for (int i = 0; i < dly; i++) begin
      tick();
      check("hold_v", tx_valid, 1);
      check("hold_d", tx_data, e_tx);
      check("hold_wr", cfg_wr, 0);
    end
    handshake("frm");
  endtask

  initial begin
    logic [7:0] got, c, d, k;
    tbl[0]  = '{8'h01, 8'h40, 8'h41, 0, 8'h06, 8'd0};
    tbl[1]  = '{8'h02, 8'h03, 8'h00, 0, 8'h15, 8'd1};
    tbl[2]  = '{8'h10, 8'h00, 8'h10, 5, 8'h40, 8'd1};
    tbl[3]  = '{8'h03, 8'h01, 8'h02, 1, 8'h06, 8'd1};
    tbl[4]  = '{8'h02, 8'h02, 8'h00, 0, 8'h06, 8'd1};
    tbl[5]  = '{8'h10, 8'h01, 8'h11, 2, 8'h02, 8'd1};
    tbl[6]  = '{8'h10, 8'h02, 8'h12, 0, 8'h01, 8'd1};
    tbl[7]  = '{8'h10, 8'h03, 8'h13, 0, 8'h15, 8'd2};
    tbl[8]  = '{8'h7F, 8'h00, 8'h7F, 0, 8'h15, 8'd3};
    tbl[9]  = '{8'h01, 8'hA5, 8'hA4, 0, 8'h06, 8'd3};
    tbl[10] = '{8'h10, 8'h00, 8'h10, 3, 8'hA5, 8'd3};

    m_reset();
    tick(); tick();
    check("rst_txv", tx_valid, 0);
    check("rst_txd", tx_data, 0);
    check("rst_wr", cfg_wr, 0);
    check_cfg("rst");
    rst_n = 1'b1;

    // Junk in IDLE is silently dropped
    send(8'h00); send(8'hFF); send(8'h7E);
    tick();
    check("junk_err", err_count, 0);
    check("junk_txv", tx_valid, 0);

    foreach (tbl[i]) begin
      run_frame(tbl[i].cmd, tbl[i].data, tbl[i].chk, tbl[i].dly, got);
      check($sformatf("tbl%0d_tx", i), got, tbl[i].exp_tx);
      check($sformatf("tbl%0d_err", i), err_count, tbl[i].exp_err);
    end

    // Overrun during RESP: counted, response untouched
    begin
      logic [7:0] r; bit w;
      m_frame(8'h01, 8'h20, 8'h21, r, w);
      send(8'hA5); send(8'h01); send(8'h20); send(8'h21);
      tick();
      send(8'h5A);
      m_bump();
      check("ovr_err", err_count, m_err);
      check("ovr_txv", tx_valid, 1);
      check("ovr_txd", tx_data, r);
      handshake("ovr");

      // NAK plus overrun in EXEC increments once
      m_frame(8'h02, 8'h03, 8'h00, r, w);
      send(8'hA5); send(8'h02); send(8'h03); send(8'h00);
      send(8'h33);
      check("dbl_err", err_count, m_err);
      check("dbl_txd", tx_data, 8'h15);
      check("dbl_mode", cfg_mode, m_mode);
      handshake("dbl");
    end

    // Inter-byte timeout
    run_frame(8'h03, 8'h00, 8'h03, 0, got);
    send(8'hA5); send(8'h03);
    for (int i = 0; i < TO - 1; i++) tick();
    check("to_early_err", err_count, m_err);
    tick();
    m_bump();
    check("to_err", err_count, m_err);
    check("to_txv", tx_valid, 0);
    run_frame(8'h03, 8'h01, 8'h02, 0, got);
    check("to_en", cfg_enable, 1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: c = 8'h01;
        1: c = 8'h02;
        2: c = 8'h03;
        3: c = 8'h10;
        default: c = 8'($urandom);
      endcase
      d = (c == 8'h10) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      k = c ^ d;
      if ($urandom_range(0, 4) == 0) k = k ^ 8'($urandom_range(1, 255));
      run_frame(c, d, k, $urandom_range(0, 3), got);
    end

    // Reset mid-frame aborts; a stray CHK afterwards is ignored
    send(8'hA5); send(8'h01);
    rst_n = 1'b0;
    #1;
    m_reset();
    check("amid_txv", tx_valid, 0);
    check("amid_txd", tx_data, 0);
    check("amid_wr", cfg_wr, 0);
    check_cfg("amid");
    tick();
    rst_n = 1'b1;
    send(8'h41);
    tick(); tick();
    check("post_txv", tx_valid, 0);
    check_cfg("post");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run_frame(8'h01, 8'h40, 8'h41, 0, got);
    check("first_edge_tx", got, 8'h06);

    // Error counter saturation via sustained overrun in RESP
    begin
      logic [7:0] r; bit w;
      m_frame(8'h01, 8'h22, 8'h23, r, w);
      send(8'hA5); send(8'h01); send(8'h22); send(8'h23);
      tick();
      rx_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
        tick();
        m_bump();
      end
      rx_valid = 1'b0;
      check("sat_err", err_count, m_err);
      check("sat_255", err_count, 8'd255);
      check("sat_txd", tx_data, r);
      check("sat_txv", tx_valid, 1);
      handshake("sat");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
